// File: rtl/siso_shift_ctrl.sv
// Serial-in/serial-out shift sequencer: loads a parallel word, shifts it out MSB-first
// with DIV clocks per bit, and captures serial_in into the same register (full duplex).
module siso_shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             abort,
  input  logic             serial_in,
  output logic             serial_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BL_W  = $clog2(WIDTH + 1);
  localparam int SR_W  = WIDTH - 1;

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO   = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [BL_W-1:0]  BITS_FULL  = BL_W'(WIDTH);
  localparam logic [BL_W-1:0]  BITS_ONE   = BL_W'(1);
  localparam logic [SR_W-1:0]  SR_ZERO    = SR_W'(0);
  localparam logic [WIDTH-1:0] RX_ZERO    = WIDTH'(0);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  // The word's MSB goes straight to serial_out on accept, so only WIDTH-1 bits are kept;
  // the top bit of shift_q is always the next transmit bit.
  logic [SR_W-1:0]  shift_q, shift_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BL_W-1:0]  bits_left_q, bits_left_d;
  logic             serial_out_q, serial_out_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign bit_strobe = (state_q == SHIFT) && (div_cnt_q == DIV_ZERO) && !abort;
  assign serial_out = serial_out_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    div_cnt_d    = div_cnt_q;
    bits_left_d  = bits_left_q;
    serial_out_d = serial_out_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d      = tx_data[SR_W-1:0];
          serial_out_d = tx_data[WIDTH-1];
          div_cnt_d    = DIV_RELOAD;
          bits_left_d  = BITS_FULL;
          state_d      = SHIFT;
        end else begin
          serial_out_d = 1'b0;
        end
      end
      SHIFT: begin
        if (abort) begin
          serial_out_d = 1'b0;
          state_d      = IDLE;
        end else if (div_cnt_q != DIV_ZERO) begin
          div_cnt_d = div_cnt_q - DIV_ONE;
        end else begin
          shift_d     = (shift_q << 1'b1) | SR_W'(serial_in);
          bits_left_d = bits_left_q - BITS_ONE;
          div_cnt_d   = DIV_RELOAD;
          if (bits_left_q != BITS_ONE) begin
            serial_out_d = shift_q[SR_W-1];
          end else begin
            rx_data_d    = {shift_q, serial_in};
            rx_valid_d   = 1'b1;
            serial_out_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: begin
        serial_out_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= SR_ZERO;
      div_cnt_q    <= DIV_ZERO;
      bits_left_q  <= BL_W'(0);
      serial_out_q <= 1'b0;
      rx_data_q    <= RX_ZERO;
      rx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      div_cnt_q    <= div_cnt_d;
      bits_left_q  <= bits_left_d;
      serial_out_q <= serial_out_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Self-checking bench for siso_shift_ctrl: one instance with DIV=1 (index 0) and one
// with DIV=3 (index 1), table-driven frames, hand-written corner cases, random frames.
module tb_siso_shift_ctrl;

  localparam int MODE_LOOP = 0;
  localparam int MODE_ONE  = 1;
  localparam int MODE_ZERO = 2;
  localparam int MODE_RAND = 3;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data    [2];
  logic       tx_valid   [2];
  logic       tx_ready   [2];
  logic       abort      [2];
  logic       serial_in  [2];
  logic       serial_out [2];
  logic       bit_strobe [2];
  logic       busy       [2];
  logic [7:0] rx_data    [2];
  logic       rx_valid   [2];
  logic       loop_en    [2];
  logic       si_drv     [2];
  logic [7:0] last_rx    [2];

  int checks = 0;
  int errors = 0;

  assign serial_in[0] = loop_en[0] ? serial_out[0] : si_drv[0];
  assign serial_in[1] = loop_en[1] ? serial_out[1] : si_drv[1];

  siso_shift_ctrl #(.WIDTH(8), .DIV(1)) u_dut_d1 (
    .clk(clk), .rst(rst),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .abort(abort[0]), .serial_in(serial_in[0]), .serial_out(serial_out[0]),
    .bit_strobe(bit_strobe[0]), .busy(busy[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0])
  );

  siso_shift_ctrl #(.WIDTH(8), .DIV(3)) u_dut_d3 (
    .clk(clk), .rst(rst),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .abort(abort[1]), .serial_in(serial_in[1]), .serial_out(serial_out[1]),
    .bit_strobe(bit_strobe[1]), .busy(busy[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", name, act, exp);
    end
  endtask

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk_idle(input int k, input string tag);
    chk_bit($sformatf("%s_tx_ready_%0d", tag, k), tx_ready[k], 1'b1);
    chk_bit($sformatf("%s_busy_%0d", tag, k), busy[k], 1'b0);
    chk_bit($sformatf("%s_serial_out_%0d", tag, k), serial_out[k], 1'b0);
    chk_bit($sformatf("%s_bit_strobe_%0d", tag, k), bit_strobe[k], 1'b0);
    chk_bit($sformatf("%s_rx_valid_%0d", tag, k), rx_valid[k], 1'b0);
    chk_byte($sformatf("%s_rx_data_%0d", tag, k), rx_data[k], last_rx[k]);
  endtask

  // Called just after a falling edge; returns just after the falling edge of the rx_valid cycle.
  task automatic run_frame(input int k, input logic [7:0] d, input int mode,
                           input logic [7:0] exp_rx, input bit hold_next, input logic [7:0] next_d);
    int         dv;
    logic       exp_strobe;
    logic [7:0] rx_m;
    logic [7:0] exp_f;
    dv = div_of(k);
    rx_m = 8'h00;
    loop_en[k] = (mode == MODE_LOOP);
    si_drv[k]  = (mode == MODE_ONE);
    tx_data[k]  = d;
    tx_valid[k] = 1'b1;
    #1;
    chk_bit($sformatf("pre_tx_ready_%0d_%02h", k, d), tx_ready[k], 1'b1);
    @(negedge clk);
    if (hold_next) begin
      tx_data[k] = next_d;
    end else begin
      tx_valid[k] = 1'b0;
      tx_data[k]  = ~d;
    end
    for (int t = 0; t < 8 * dv; t++) begin
      if (mode == MODE_RAND) si_drv[k] = 1'($urandom);
      #1;
      exp_strobe = ((t % dv) == (dv - 1));
      chk_bit($sformatf("serial_out_%0d_%02h_t%0d", k, d, t), serial_out[k], d[7 - t / dv]);
      chk_bit($sformatf("bit_strobe_%0d_%02h_t%0d", k, d, t), bit_strobe[k], exp_strobe);
      chk_bit($sformatf("busy_%0d_t%0d", k, t), busy[k], 1'b1);
      chk_bit($sformatf("tx_ready_%0d_t%0d", k, t), tx_ready[k], 1'b0);
      chk_bit($sformatf("rx_valid_%0d_t%0d", k, t), rx_valid[k], 1'b0);
      if (exp_strobe) rx_m = {rx_m[6:0], si_drv[k]};
      @(negedge clk);
    end
    exp_f = (mode == MODE_RAND) ? rx_m : exp_rx;
    last_rx[k] = exp_f;
    #1;
    chk_bit($sformatf("end_rx_valid_%0d_%02h", k, d), rx_valid[k], 1'b1);
    chk_byte($sformatf("end_rx_data_%0d_%02h", k, d), rx_data[k], exp_f);
    chk_bit($sformatf("end_tx_ready_%0d", k), tx_ready[k], 1'b1);
    chk_bit($sformatf("end_busy_%0d", k), busy[k], 1'b0);
    chk_bit($sformatf("end_serial_out_%0d", k), serial_out[k], 1'b0);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         mode;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{0, 8'hA5, MODE_LOOP, 8'hA5};
    vecs[1] = '{1, 8'h3C, MODE_ONE,  8'hFF};
    vecs[2] = '{0, 8'h3C, MODE_ONE,  8'hFF};
    vecs[3] = '{0, 8'h81, MODE_ZERO, 8'h00};
    vecs[4] = '{1, 8'hA5, MODE_LOOP, 8'hA5};
    vecs[5] = '{1, 8'h7E, MODE_ZERO, 8'h00};
    vecs[6] = '{0, 8'h01, MODE_LOOP, 8'h01};

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tx_data[k] = 8'h00; tx_valid[k] = 1'b0; abort[k] = 1'b0;
      loop_en[k] = 1'b0; si_drv[k] = 1'b0; last_rx[k] = 8'h00;
    end
    #2;
    for (int k = 0; k < 2; k++) chk_idle(k, "reset");
    #10 rst = 1'b0;
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk_idle(k, "post_reset");

    // Table-driven frames; a second idle cycle checks that rx_valid is a single pulse.
    foreach (vecs[i]) begin
      run_frame(vecs[i].inst, vecs[i].data, vecs[i].mode, vecs[i].exp_rx, 1'b0, 8'h00);
      @(negedge clk);
      #1;
      chk_idle(vecs[i].inst, $sformatf("gap_v%0d", i));
    end

    // tx_valid held with new data during a frame: consumed only at the rx_valid cycle.
    run_frame(0, 8'hA5, MODE_LOOP, 8'hA5, 1'b1, 8'h11);
    run_frame(0, 8'h11, MODE_LOOP, 8'h11, 1'b0, 8'h00);
    @(negedge clk);

    // Abort in the fourth shifting cycle; abort beats the strobe, rx_data is retained.
    loop_en[0] = 1'b1;
    tx_data[0] = 8'hA5; tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    abort[0] = 1'b1;
    #1;
    chk_bit("abort_strobe_suppressed", bit_strobe[0], 1'b0);
    chk_bit("abort_busy_same_cycle", busy[0], 1'b1);
    @(negedge clk);
    abort[0] = 1'b0;
    #1;
    chk_idle(0, "after_abort");
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      #1;
      chk_bit($sformatf("abort_no_rx_valid_c%0d", c), rx_valid[0], 1'b0);
    end
    abort[0] = 1'b1;
    #1;
    chk_bit("abort_in_idle_ready", tx_ready[0], 1'b1);
    @(negedge clk);
    abort[0] = 1'b0;
    run_frame(0, 8'hC6, MODE_LOOP, 8'hC6, 1'b0, 8'h00);
    @(negedge clk);

    // Asynchronous reset in the middle of a frame and mid-cycle.
    tx_data[0] = 8'hC3; tx_valid[0] = 1'b1; loop_en[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    last_rx[0] = 8'h00;
    last_rx[1] = 8'h00;
    for (int k = 0; k < 2; k++) chk_idle(k, "mid_frame_reset");
    @(negedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk_bit($sformatf("reset_no_rx_valid_c%0d", c), rx_valid[0], 1'b0);
    end
    @(negedge clk);
    run_frame(0, 8'h5A, MODE_LOOP, 8'h5A, 1'b0, 8'h00);
    @(negedge clk);

    // Random frames with random serial_in, checked against the bench model.
    for (int n = 0; n < 12; n++) begin
      int         k;
      int         gap;
      logic [7:0] d;
      k   = int'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 2));
      d   = 8'($urandom);
      run_frame(k, d, MODE_RAND, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      repeat (gap) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
